// File: rtl/byte_a_palabra.sv
// Byte-to-word receive converter: packs a byte stream into 32/16/8-bit words selected by PCLK.
// Optional comma alignment (8'hBC) is enabled by defining BYTE_A_PALABRA_ALIGN_EN.
module byte_a_palabra (
  input  logic        CLK,
  input  logic        RESET_L,
  input  logic        ENB,
  input  logic [1:0]  PCLK,
  input  logic [7:0]  in_8,
  input  logic        valid_in,
  output logic [31:0] out_32,
  output logic        valid_out,
  output logic        partial
);

  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [WORD_W-1:0]   acc_q, acc_d;
  logic [1:0]          mode_q;
  logic [WORD_W-1:0]   out_d;
  logic                valid_d;
  logic                partial_d;

  logic [2:0]          n_bytes;
  logic [2:0]          base_cnt;
  logic [2:0]          cnt_inc;
  logic [WORD_W-1:0]   base_acc;
  logic [WORD_W-1:0]   acc_sh;
  logic                take;

`ifdef BYTE_A_PALABRA_ALIGN_EN
  localparam logic [BYTE_W-1:0] COMMA = 8'hBC;
  logic aligned_q, aligned_d;
`endif

  always_comb begin
    unique case (PCLK)
      2'b01:   n_bytes = 3'd2;
      2'b10:   n_bytes = 3'd1;
      default: n_bytes = 3'd4;
    endcase
  end

  // NOTE: every combinational output gets a default first, so no path leaves a latch behind.
  always_comb begin
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    out_d     = out_32;
    valid_d   = 1'b0;
    base_cnt  = cnt_q;
    base_acc  = acc_q;
    acc_sh    = '0;
    cnt_inc   = '0;
    take      = 1'b0;
`ifdef BYTE_A_PALABRA_ALIGN_EN
    aligned_d = aligned_q;
`endif

    if (!ENB) begin
      cnt_d = '0;
      acc_d = '0;
      out_d = '0;
`ifdef BYTE_A_PALABRA_ALIGN_EN
      aligned_d = 1'b0;
`endif
    end else begin
      // A width change mid-word invalidates the bytes gathered so far.
      if (state_q == COLLECT && PCLK != mode_q) begin
        base_cnt = '0;
        base_acc = '0;
      end
`ifdef BYTE_A_PALABRA_ALIGN_EN
      take = valid_in && (aligned_q || in_8 == COMMA);
      if (valid_in && in_8 == COMMA) begin
        aligned_d = 1'b1;
        base_cnt  = '0;
        base_acc  = '0;
      end
`else
      take = valid_in;
`endif
      cnt_d = base_cnt;
      acc_d = base_acc;
      if (take) begin
        acc_sh  = {base_acc[WORD_W-BYTE_W-1:0], in_8};
        cnt_inc = base_cnt + 3'd1;
        if (cnt_inc == n_bytes) begin
          // Accumulator restarts from zero, so narrow words come out zero-extended.
          out_d   = acc_sh;
          valid_d = 1'b1;
          cnt_d   = '0;
          acc_d   = '0;
        end else begin
          cnt_d = cnt_inc;
          acc_d = acc_sh;
        end
      end
    end

    state_d   = (cnt_d != 3'd0) ? COLLECT : IDLE;
    partial_d = (cnt_d != 3'd0);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      mode_q    <= 2'b00;
      out_32    <= '0;
      valid_out <= 1'b0;
      partial   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mode_q    <= PCLK;
      out_32    <= out_d;
      valid_out <= valid_d;
      partial   <= partial_d;
    end
  end

`ifdef BYTE_A_PALABRA_ALIGN_EN
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) aligned_q <= 1'b0;
    else          aligned_q <= aligned_d;
  end
`endif

endmodule

// File: tb/tb_byte_a_palabra.sv
// Self-checking bench for byte_a_palabra: vector table plus a word scoreboard,
// with hand-written reset-mid-word and comma-alignment sequences.
module tb_byte_a_palabra;

  logic        CLK;
  logic        RESET_L;
  logic        ENB;
  logic [1:0]  PCLK;
  logic [7:0]  in_8;
  logic        valid_in;
  logic [31:0] out_32;
  logic        valid_out;
  logic        partial;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        enb;
    logic [1:0]  pclk;
    logic        vin;
    logic [7:0]  din;
    logic [31:0] exp_out;
    logic        exp_v;
    logic        exp_p;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] sb[$];

  byte_a_palabra dut (
    .CLK      (CLK),
    .RESET_L  (RESET_L),
    .ENB      (ENB),
    .PCLK     (PCLK),
    .in_8     (in_8),
    .valid_in (valid_in),
    .out_32   (out_32),
    .valid_out(valid_out),
    .partial  (partial)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic void add(input logic enb, input logic [1:0] pclk, input logic vin,
                              input logic [7:0] din, input logic [31:0] exp_out,
                              input logic exp_v, input logic exp_p);
    vec_t v;
    v.enb = enb; v.pclk = pclk; v.vin = vin; v.din = din;
    v.exp_out = exp_out; v.exp_v = exp_v; v.exp_p = exp_p;
    vecs.push_back(v);
  endfunction

  // Drive one vector, clock it in, then sample #1 after the edge.
  task automatic apply(input vec_t v, input string tag);
    logic [31:0] exp_word;
    ENB      = v.enb;
    PCLK     = v.pclk;
    valid_in = v.vin;
    in_8     = v.din;
    if (v.exp_v) sb.push_back(v.exp_out);
    @(posedge CLK);
    #1;
    check({tag, "_out"},     out_32,            v.exp_out);
    check({tag, "_valid"},   {31'b0, valid_out}, {31'b0, v.exp_v});
    check({tag, "_partial"}, {31'b0, partial},   {31'b0, v.exp_p});
    if (valid_out) begin
      if (sb.size() == 0) begin
        check({tag, "_sb_unexpected_word"}, out_32, 32'hxxxx_xxxx);
      end else begin
        exp_word = sb.pop_front();
        check({tag, "_sb_word"}, out_32, exp_word);
      end
    end
  endtask

  task automatic run_table(input string prefix);
    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], $sformatf("%s%0d", prefix, i));
    end
    vecs.delete();
  endtask

  initial begin
    RESET_L  = 1'b0;
    ENB      = 1'b0;
    PCLK     = 2'b00;
    in_8     = 8'h00;
    valid_in = 1'b0;
    #12;
    check("reset_out",     out_32,             32'h0);
    check("reset_valid",   {31'b0, valid_out}, 32'h0);
    check("reset_partial", {31'b0, partial},   32'h0);
    @(posedge CLK);
    #1;
    RESET_L = 1'b1;

`ifndef BYTE_A_PALABRA_ALIGN_EN
    // 32-bit word, one-cycle pulse, partial during bytes 1-3
    add(1, 2'b00, 1, 8'hDE, 32'h0,        0, 1);
    add(1, 2'b00, 1, 8'hAD, 32'h0,        0, 1);
    add(1, 2'b00, 1, 8'hBE, 32'h0,        0, 1);
    add(1, 2'b00, 1, 8'hEF, 32'hDEADBEEF, 1, 0);
    add(1, 2'b00, 0, 8'h00, 32'hDEADBEEF, 0, 0);
    // 16-bit words
    add(1, 2'b01, 1, 8'h12, 32'hDEADBEEF, 0, 1);
    add(1, 2'b01, 1, 8'h34, 32'h00001234, 1, 0);
    add(1, 2'b01, 1, 8'h56, 32'h00001234, 0, 1);
    add(1, 2'b01, 1, 8'h78, 32'h00005678, 1, 0);
    // 8-bit: every byte is a word; 8'hBC is plain data here
    add(1, 2'b10, 1, 8'hA5, 32'h000000A5, 1, 0);
    add(1, 2'b10, 1, 8'hBC, 32'h000000BC, 1, 0);
    add(1, 2'b10, 0, 8'h00, 32'h000000BC, 0, 0);
    // gap of three idle cycles mid-word
    add(1, 2'b00, 1, 8'h11, 32'h000000BC, 0, 1);
    add(1, 2'b00, 1, 8'h22, 32'h000000BC, 0, 1);
    add(1, 2'b00, 0, 8'hFF, 32'h000000BC, 0, 1);
    add(1, 2'b00, 0, 8'hFF, 32'h000000BC, 0, 1);
    add(1, 2'b00, 0, 8'hFF, 32'h000000BC, 0, 1);
    add(1, 2'b00, 1, 8'h33, 32'h000000BC, 0, 1);
    add(1, 2'b00, 1, 8'h44, 32'h11223344, 1, 0);
    // ENB low flushes a partial word and clears out_32
    add(1, 2'b00, 1, 8'h11, 32'h11223344, 0, 1);
    add(1, 2'b00, 1, 8'h22, 32'h11223344, 0, 1);
    add(0, 2'b00, 1, 8'h99, 32'h0,        0, 0);
    add(1, 2'b00, 1, 8'hAA, 32'h0,        0, 1);
    add(1, 2'b00, 1, 8'hBB, 32'h0,        0, 1);
    add(1, 2'b00, 1, 8'hCC, 32'h0,        0, 1);
    add(1, 2'b00, 1, 8'hDD, 32'hAABBCCDD, 1, 0);
    // width change mid-word drops the partial word
    add(1, 2'b00, 1, 8'h11, 32'hAABBCCDD, 0, 1);
    add(1, 2'b01, 1, 8'h22, 32'hAABBCCDD, 0, 1);
    add(1, 2'b01, 1, 8'h33, 32'h00002233, 1, 0);
    // PCLK = 11 also means 32-bit
    add(1, 2'b11, 1, 8'h01, 32'h00002233, 0, 1);
    add(1, 2'b11, 1, 8'h02, 32'h00002233, 0, 1);
    add(1, 2'b11, 1, 8'h03, 32'h00002233, 0, 1);
    add(1, 2'b11, 1, 8'h04, 32'h01020304, 1, 0);
    run_table("tbl");

    // Reset mid-word: asynchronous clear, lost bytes never surface.
    add(1, 2'b00, 1, 8'h77, 32'h01020304, 0, 1);
    add(1, 2'b00, 1, 8'h88, 32'h01020304, 0, 1);
    run_table("pre_rst");
    valid_in = 1'b0;
    #2;
    RESET_L = 1'b0;
    #1;
    check("rst_mid_out",     out_32,             32'h0);
    check("rst_mid_valid",   {31'b0, valid_out}, 32'h0);
    check("rst_mid_partial", {31'b0, partial},   32'h0);
    @(posedge CLK);
    #1;
    RESET_L = 1'b1;
    add(1, 2'b00, 1, 8'h33, 32'h0,        0, 1);
    add(1, 2'b00, 1, 8'h44, 32'h0,        0, 1);
    add(1, 2'b00, 1, 8'h55, 32'h0,        0, 1);
    add(1, 2'b00, 1, 8'h66, 32'h33445566, 1, 0);
    run_table("post_rst");
`else
    // Unaligned bytes dropped until the comma; comma is byte0.
    add(1, 2'b00, 1, 8'h01, 32'h0,        0, 0);
    add(1, 2'b00, 1, 8'h02, 32'h0,        0, 0);
    add(1, 2'b00, 1, 8'hBC, 32'h0,        0, 1);
    add(1, 2'b00, 1, 8'h10, 32'h0,        0, 1);
    add(1, 2'b00, 1, 8'h20, 32'h0,        0, 1);
    add(1, 2'b00, 1, 8'h30, 32'hBC102030, 1, 0);
    // A comma mid-word restarts the word.
    add(1, 2'b00, 1, 8'hBC, 32'hBC102030, 0, 1);
    add(1, 2'b00, 1, 8'h11, 32'hBC102030, 0, 1);
    add(1, 2'b00, 1, 8'hBC, 32'hBC102030, 0, 1);
    add(1, 2'b00, 1, 8'h22, 32'hBC102030, 0, 1);
    add(1, 2'b00, 1, 8'h33, 32'hBC102030, 0, 1);
    add(1, 2'b00, 1, 8'h44, 32'hBC223344, 1, 0);
    // ENB low drops alignment again.
    add(0, 2'b00, 0, 8'h00, 32'h0,        0, 0);
    add(1, 2'b10, 1, 8'h5A, 32'h0,        0, 0);
    add(1, 2'b10, 1, 8'hBC, 32'h000000BC, 1, 0);
    add(1, 2'b10, 1, 8'h5A, 32'h0000005A, 1, 0);
    run_table("align");
`endif

    check("sb_leftover", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/byte_a_palabra.md
Name: byte_a_palabra

Overview:
- Receive-side neighbour of the 32-to-8 transmit converter: reassembles the 8-bit byte stream into 32/16/8-bit parallel words.
- Word width is selected by the same PCLK[1:0] code used on the transmit side.
- Byte order matches the transmitter: the first byte received lands in the most significant lane of the selected width.
- Sits between the byte-wide link and the PIPE-side parallel interface; one clock domain (CLK, byte rate).

Parameters:
- BYTE_W, 8, width of the input byte; fixed at 8, not to be overridden.
- WORD_W, 32, width of the output word; fixed at 32, not to be overridden.

Ports:
- CLK  input  1  byte-rate clock; all state changes on its rising edge.
- RESET_L  input  1  asynchronous, active-low reset.
- ENB  input  1  block enable; low = flush and hold idle.
- PCLK  input  2  width select: 00 = 32-bit, 01 = 16-bit, 10 = 8-bit, 11 = 32-bit.
- in_8  input  8  incoming byte.
- valid_in  input  1  in_8 carries a valid byte this cycle.
- out_32  output  32  assembled word; unused upper lanes are 0.
- valid_out  output  1  one-cycle pulse: out_32 holds a newly completed word.
- partial  output  1  high while 1 or more bytes of an incomplete word are buffered.

Behaviour:
- Reset (RESET_L low, asynchronous): out_32 = 0, valid_out = 0, partial = 0, byte counter = 0, accumulator = 0, last-mode register = 00.
- Bytes per word (N), decoded from PCLK: 00 or 11 -> 4, 01 -> 2, 10 -> 1.
- States:
  - IDLE: counter = 0.
  - COLLECT: 0 < counter < N.
- Rising edge with ENB = 1 and valid_in = 1:
  - Byte is shifted into the accumulator; counter increments.
  - If the counter reaches N: out_32 <= the assembled word, zero-extended; valid_out = 1 for exactly that cycle; counter = 0; return to IDLE.
  - Latency: valid_out and out_32 are visible immediately after the edge that samples the final byte.
- Lane mapping:
  - 32-bit: byte0 -> [31:24], byte1 -> [23:16], byte2 -> [15:8], byte3 -> [7:0].
  - 16-bit: byte0 -> [15:8], byte1 -> [7:0], [31:16] = 0.
  - 8-bit: byte0 -> [7:0], [31:8] = 0; every valid byte yields valid_out.
- valid_in = 0 with ENB = 1: no advance; accumulator, counter and out_32 are held; valid_out = 0. Gaps of any length between bytes are legal.
- out_32 changes only on word completion, on ENB = 0, or on reset. Otherwise it holds the last word.
- ENB = 0 at any edge: counter = 0, accumulator = 0, out_32 = 0, valid_out = 0, partial = 0. A partial word is discarded.
- PCLK change: PCLK is registered each cycle as the last-mode register. If PCLK differs from the registered value while in COLLECT, the partial word is discarded. The byte present on that same edge (if valid) is taken as byte0 of a word in the new mode.
- partial = (counter != 0), registered.
- Reset asserted mid-word: all state is cleared immediately; no valid_out is produced for the lost partial word.

Optional Feature:
- Macro: BYTE_A_PALABRA_ALIGN_EN.
- Defined:
  - An internal aligned flag is added, cleared by reset and by ENB = 0.
  - While unaligned, valid bytes are discarded. The first valid byte equal to 8'hBC (comma) sets aligned and is stored as byte0.
  - While aligned, an 8'hBC arriving at counter != 0 discards the partial word and restarts with that byte as byte0.
  - partial stays 0 while unaligned.
- Not defined: no comma checking; the first valid byte after reset or ENB rising is byte0, and 8'hBC is ordinary data.

Test Plan:
- PCLK = 00, ENB = 1, bytes 8'hDE, 8'hAD, 8'hBE, 8'hEF on 4 consecutive cycles -> after the 4th edge out_32 = 32'hDEADBEEF, valid_out high for exactly 1 cycle, partial = 1 after bytes 1-3.
- PCLK = 01, bytes 12, 34, 56, 78 -> two pulses: out_32 = 32'h00001234, then 32'h00005678. PCLK = 10 with byte A5 -> out_32 = 32'h000000A5 and a pulse every valid byte.
- PCLK = 00, bytes 11, 22, then valid_in = 0 for 3 cycles, then 33, 44 -> single pulse with out_32 = 32'h11223344; out_32 unchanged and no pulse during the gap.
- PCLK = 00, bytes 11, 22, then ENB = 0 for 1 cycle, then ENB = 1 with 4 bytes AA, BB, CC, DD -> out_32 = 0 during the ENB-low cycle, then 32'hAABBCCDD; 11/22 never appear.
- PCLK = 00, byte 11, then PCLK -> 01 with bytes 22, 33 -> partial word dropped; out_32 = 32'h00002233, single pulse. RESET_L pulsed low mid-word -> all outputs 0 asynchronously, no pulse afterwards.
- ALIGN_EN defined: bytes 01, 02, BC, 10, 20, 30 with PCLK = 00 -> out_32 = 32'hBC102030; bytes 01 and 02 are dropped and partial stays 0 until BC.
